tdm_demux_8: RTL and testbench
==============================

# tdm_demux_8

Serial-to-parallel time-division demultiplexer: the receive end of an 8-slot TDM link whose transmitter walks a 3-bit select through an 8:1 mux. Bits arrive one per accepted cycle, slot 0 marked by a frame-sync flag. Each bit is routed to its slot position, and each complete frame is presented as an 8-bit word with a one-cycle valid strobe. The block handles lock acquisition, mid-frame resync and missing-sync errors.

## Interface
- No parameters. Slot count is fixed at 8 and the slot index is 3 bits.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_bit  in  1  serial data bit.
- in_valid  in  1  in_bit is valid this cycle.
- in_sync  in  1  qualified by in_valid: the current bit is slot 0.
- err_clr  in  1  clears sync_err.
- data_out  out  8  last complete frame; bit i is slot i.
- data_valid  out  1  one-cycle strobe: data_out was updated.
- slot_idx  out  3  slot the next accepted bit will fill.
- locked  out  1  FSM is in COLLECT.
- sync_err  out  1  sticky framing-error flag.
- frame_cnt  out  8  count of complete frames, wraps 255→0.

## Operation
- Accept event: in_valid=1 on a rising edge. Cycles with in_valid=0 change nothing except the data_valid return to 0 and err_clr.
- State HUNT (reset state):
  - Accepted bit with in_sync=0 is discarded.
  - Accepted bit with in_sync=1 is written to shadow[0], slot_idx becomes 1, state goes to COLLECT.
- State COLLECT, accepted bit at slot_idx=s:
  - s=0, in_sync=1: write shadow[0], slot_idx becomes 1.
  - s=0, in_sync=0: missing sync. Set sync_err, discard the bit, go to HUNT, slot_idx becomes 0.
  - s in 1..7, in_sync=0: write shadow[s], slot_idx becomes s+1 mod 8.
  - s in 1..7, in_sync=1: early sync / resync. Set sync_err, discard the partial frame (no data_valid), write the bit to shadow[0], slot_idx becomes 1, stay in COLLECT.
  - s=7 completing normally: on the next edge, data_out gets shadow[6:0] plus the slot-7 bit, data_valid=1 and frame_cnt increments. slot_idx wraps to 0.
- data_out changes only on a data_valid strobe. Between strobes it holds the last frame.
- The shadow register is internal and is not visible on data_out mid-frame.
- sync_err:
  - Set on either error condition and held.
  - err_clr=1 clears it.
  - If err_clr and a new error occur in the same cycle, the error wins and sync_err stays 1.
- locked=1 exactly when the state is COLLECT.

## Timing
- Reset (asynchronous, immediate):
  - State HUNT, slot_idx=0, locked=0.
  - data_out=8'h00, data_valid=0, sync_err=0, frame_cnt=8'h00.
  - Shadow cleared.
- Reset mid-frame drops the partial frame. No data_valid is issued for it.
- Latency: data_valid rises on the same edge that samples the slot-7 bit, i.e. data_out and data_valid are registered outputs visible in the cycle after the slot-7 bit is presented. Latency is 1 clock from the slot-7 input.
- Back-to-back frames:
  - With in_valid held high, data_valid pulses every 8 cycles.
  - The slot-0 bit of the next frame is accepted in the same cycle data_valid is high; the two do not conflict.
- Gaps: in_valid=0 cycles inside a frame only stretch the frame. No timeout.
- locked and slot_idx update on the same edge as the triggering accept.
- frame_cnt wraps from 255 to 0 without a flag.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Lock and single frame: after reset, send 8 bits with in_valid=1 continuously, sync on the first bit, bits = 1,0,1,1,0,0,1,0 for slots 0..7.
  - Required: data_out=8'h4D and data_valid=1 for exactly one cycle, 1 cycle after the slot-7 bit.
  - Required: frame_cnt=1, locked=1, sync_err=0.
- Hunt discard: send 5 accepted bits with in_sync=0 before the first sync, then frame 8'hA5.
  - Required: the first 5 bits are ignored, locked stays 0 until the sync bit, output is 8'hA5.
- Gapped back-to-back frames: send frames 8'h3C and 8'hC3 with in_valid=0 inserted after slots 2 and 5.
  - Required: two strobes, values 8'h3C then 8'hC3.
  - Required: data_out holds between the strobes, frame_cnt=2.
- Early sync: after slots 0..3 of a frame, present in_sync=1, then complete frame 8'hFF.
  - Required: sync_err=1 and no strobe for the partial frame, then data_out=8'hFF.
  - Then: err_clr pulse returns sync_err to 0. err_clr asserted in the same cycle as a new error leaves sync_err=1.
- Missing sync: after a good frame, the next slot-0 bit has in_sync=0.
  - Required: sync_err=1, locked=0, slot_idx=0.
  - Required: the following non-sync bits are ignored until the next sync.
- Reset mid-frame and wrap: assert rst at slot 4.
  - Required: all outputs reach their reset values immediately, and no strobe follows.
  - Then: run 256 frames. Required: frame_cnt returns to 0.

Source files
------------

// File: rtl/tdm_demux_8_if.sv
// tdm_demux_8_if: serial TDM input and parallel frame output bundle.
// Ports: in_bit/in_valid/in_sync serial bit with its slot-0 marker, err_clr clears sync_err,
// data_out/data_valid frame word and strobe, slot_idx next slot, locked, sync_err, frame_cnt.
interface tdm_demux_8_if;
    logic       in_bit;
    logic       in_valid;
    logic       in_sync;
    logic       err_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic [2:0] slot_idx;
    logic       locked;
    logic       sync_err;
    logic [7:0] frame_cnt;
    modport master (
        output in_bit, in_valid, in_sync, err_clr,
        input  data_out, data_valid, slot_idx, locked, sync_err, frame_cnt
    );
    modport slave (
        input  in_bit, in_valid, in_sync, err_clr,
        output data_out, data_valid, slot_idx, locked, sync_err, frame_cnt
    );
endinterface

// File: rtl/tdm_demux_8.sv
// tdm_demux_8: 8-slot TDM serial-to-parallel demux with frame lock and sync error tracking.
// Ports: clk rising-edge clock, rst async active-high reset, bus slave side of tdm_demux_8_if.
module tdm_demux_8 (
    input logic           clk,
    input logic           rst,
    tdm_demux_8_if.slave  bus
);
    typedef enum logic {HUNT, COLLECT} state_t;
    state_t     state_q, state_d;
    logic [2:0] slot_q, slot_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            slot_q   <= 3'd0;
            shadow_q <= 8'h00;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        // a new error below overrides this clear
        err_d    = bus.err_clr ? 1'b0 : err_q;
        cnt_d    = cnt_q;
        if (bus.in_valid) begin
            if (bus.in_sync) begin
                // sync always restarts the frame; mid-frame it is a resync error
                shadow_d[0] = bus.in_bit;
                slot_d      = 3'd1;
                state_d     = COLLECT;
                if (state_q == COLLECT && slot_q != 3'd0)
                    err_d = 1'b1;
            end else if (state_q == COLLECT) begin
                if (slot_q == 3'd0) begin
                    err_d   = 1'b1;
                    state_d = HUNT;
                end else begin
                    shadow_d[slot_q] = bus.in_bit;
                    slot_d           = slot_q + 3'd1;
                    if (slot_q == 3'd7) begin
                        data_d  = shadow_d;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
            end
        end
    end
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.slot_idx   = slot_q;
    assign bus.locked     = (state_q == COLLECT);
    assign bus.sync_err   = err_q;
    assign bus.frame_cnt  = cnt_q;
endmodule

// File: tb/tb_tdm_demux_8.sv
// tb_tdm_demux_8: directed and randomized checks of tdm_demux_8 against a frame-level model.
module tb_tdm_demux_8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    tdm_demux_8_if bus();
    tdm_demux_8 dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    bit         m_locked;
    bit         m_bits[$];
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_err;
    logic [7:0] m_cnt;
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        m_locked = 0;
        m_bits.delete();
        m_data = 8'h00;
        m_valid = 1'b0;
        m_err = 1'b0;
        m_cnt = 8'h00;
    endtask
    task automatic model_accept(input bit b, input bit s, input bit v, input bit c);
        logic [7:0] w;
        m_valid = 1'b0;
        if (c) m_err = 1'b0;
        if (!v) return;
        if (s) begin
            if (m_locked && m_bits.size() != 0) m_err = 1'b1;
            m_locked = 1;
            m_bits.delete();
            m_bits.push_back(b);
        end else if (m_locked) begin
            if (m_bits.size() == 0) begin
                m_err = 1'b1;
                m_locked = 0;
            end else begin
                m_bits.push_back(b);
                if (m_bits.size() == 8) begin
                    w = 8'h00;
                    foreach (m_bits[i]) w = w | (8'(m_bits[i]) << i);
                    m_data = w;
                    m_valid = 1'b1;
                    m_cnt = m_cnt + 8'd1;
                    m_bits.delete();
                end
            end
        end
    endtask
    task automatic check_all();
        chk("data_out", bus.data_out, m_data);
        chk("data_valid", {7'd0, bus.data_valid}, {7'd0, m_valid});
        chk("slot_idx", {5'd0, bus.slot_idx}, m_locked ? 8'(m_bits.size()) : 8'd0);
        chk("locked", {7'd0, bus.locked}, {7'd0, m_locked});
        chk("sync_err", {7'd0, bus.sync_err}, {7'd0, m_err});
        chk("frame_cnt", bus.frame_cnt, m_cnt);
    endtask
    task automatic step(input bit b, input bit s, input bit v, input bit c);
        bus.in_bit = b;
        bus.in_sync = s;
        bus.in_valid = v;
        bus.err_clr = c;
        @(posedge clk);
        model_accept(b, s, v, c);
        #1;
        check_all();
    endtask
    task automatic idle();
        step(1'($urandom), 1'($urandom), 1'b0, 1'b0);
    endtask
    task automatic send_frame(input logic [7:0] w, input logic [7:0] gaps);
        for (int i = 0; i < 8; i++) begin
            step(w[i], i == 0, 1'b1, 1'b0);
            if (gaps[i]) idle();
        end
    endtask
    initial begin
        logic [7:0] w;
        bus.in_bit = 0;
        bus.in_sync = 0;
        bus.in_valid = 0;
        bus.err_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        // lock and single frame: slots 0..7 = 1,0,1,1,0,0,1,0
        send_frame(8'h4D, 8'h00);
        chk("lock_frame_data", bus.data_out, 8'h4D);
        chk("lock_frame_strobe", {7'd0, bus.data_valid}, 8'd1);
        chk("lock_frame_cnt", bus.frame_cnt, 8'd1);
        idle();
        chk("lock_strobe_one_cycle", {7'd0, bus.data_valid}, 8'd0);
        // hunt discard after losing lock via missing sync
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("miss_sync_err", {7'd0, bus.sync_err}, 8'd1);
        chk("miss_sync_locked", {7'd0, bus.locked}, 8'd0);
        chk("miss_sync_slot", {5'd0, bus.slot_idx}, 8'd0);
        for (int i = 0; i < 5; i++) step(1'($urandom), 1'b0, 1'b1, 1'b0);
        chk("hunt_stay_unlocked", {7'd0, bus.locked}, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("err_clr", {7'd0, bus.sync_err}, 8'd0);
        send_frame(8'hA5, 8'h00);
        chk("hunt_frame", bus.data_out, 8'hA5);
        // gapped back-to-back frames
        send_frame(8'h3C, 8'b0010_0100);
        chk("gap_frame1", bus.data_out, 8'h3C);
        send_frame(8'hC3, 8'b0010_0100);
        chk("gap_frame2", bus.data_out, 8'hC3);
        chk("gap_cnt", bus.frame_cnt, 8'd4);
        // early sync, then same-cycle clear and new error
        for (int i = 0; i < 4; i++) step(1'b0, i == 0, 1'b1, 1'b0);
        send_frame(8'hFF, 8'h00);
        chk("early_frame", bus.data_out, 8'hFF);
        chk("early_err", {7'd0, bus.sync_err}, 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_vs_err", {7'd0, bus.sync_err}, 8'd1);
        // randomized frames with gaps and occasional errors
        for (int n = 0; n < 200; n++) begin
            bit v = ($urandom_range(0, 3) != 0);
            bit s = ($urandom_range(0, 11) == 0) || (m_locked && m_bits.size() == 0 && $urandom_range(0, 15) != 0)
                    || (!m_locked && $urandom_range(0, 2) == 0);
            step(1'($urandom), s, v, $urandom_range(0, 19) == 0);
        end
        // reset mid-frame at slot 4
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'($urandom), i == 0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_async_data", bus.data_out, 8'h00);
        chk("rst_async_slot", {5'd0, bus.slot_idx}, 8'd0);
        chk("rst_async_cnt", bus.frame_cnt, 8'd0);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'($urandom), 1'b0, 1'b1, 1'b0);
        // 256 frames wrap frame_cnt
        for (int n = 0; n < 256; n++) begin
            w = 8'($urandom);
            send_frame(w, 8'h00);
            chk("wrap_data", bus.data_out, w);
        end
        chk("wrap_cnt", bus.frame_cnt, 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
